// File: rtl/dac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_seq_pkg
//  Description : Shared constants and state encoding for the square-wave
//                voltammetry DAC sequencer (word indices, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_seq_pkg;

    localparam int NUM_WORDS = 7;   // configuration words per segment
    localparam int WORD_W    = 16;  // width of one configuration word
    localparam int ABORT_CYC = 2;   // cycles eng_rst is held during an abort

    // Order in which the engine expects its configuration words
    localparam logic [2:0] W_ADC_REF  = 3'd0;
    localparam logic [2:0] W_E_INIT   = 3'd1;
    localparam logic [2:0] W_E_RAISE  = 3'd2;
    localparam logic [2:0] W_E_FALL   = 3'd3;
    localparam logic [2:0] W_TMAX_HI  = 3'd4;
    localparam logic [2:0] W_TMAX_LO  = 3'd5;
    localparam logic [2:0] W_STEP_MAX = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ARM     = 3'd2,
        S_WAIT_EN = 3'd3,
        S_RUN     = 3'd4,
        S_NEXT    = 3'd5,
        S_ABORT   = 3'd6
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/dac_seq_word_loader.sv
`default_nettype none
// ============================================================================
//  Module      : dac_seq_word_loader
//  Description : Serialises the 7 configuration words of one segment onto the
//                engine data bus. Each word: SETTLE_CYC cycles of setup,
//                TRIG_WIDTH cycles of update strobe, SETTLE_CYC cycles of hold.
//                Emits a one-cycle done pulse after the last word.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_seq_word_loader
    import dac_seq_pkg::*;
#(
    parameter int TRIG_WIDTH = 2,
    parameter int SETTLE_CYC = 4
)(
    input  logic                        ti_clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic                        i_clear,
    input  logic [NUM_WORDS*WORD_W-1:0] i_words,
    output logic [WORD_W-1:0]           o_data,
    output logic                        o_update,
    output logic                        o_done
);

    localparam int WORD_CYC = 2*SETTLE_CYC + TRIG_WIDTH;
    localparam int CNT_W    = $clog2(WORD_CYC + 1);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(WORD_CYC - 1);
    localparam logic [CNT_W-1:0] C_UPD_LO = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] C_UPD_HI = CNT_W'(SETTLE_CYC + TRIG_WIDTH);
    localparam logic [2:0]       C_LAST_W = 3'(NUM_WORDS - 1);

    logic              r_active;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_w;
    logic [WORD_W-1:0] r_data;
    logic              r_done;
    logic [2:0]        w_next_w;

    assign w_next_w = r_w + 3'd1;

    // Word/phase counters; data register only changes at a word boundary so it
    // stays stable around the strobe and holds its value once the load ends.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_w      <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_clear) begin
                r_active <= 1'b0;
                r_cnt    <= '0;
                r_w      <= '0;
            end else if (i_start) begin
                r_active <= 1'b1;
                r_cnt    <= '0;
                r_w      <= '0;
                r_data   <= i_words[0 +: WORD_W];
            end else if (r_active) begin
                if (r_cnt == C_LAST) begin
                    r_cnt <= '0;
                    if (r_w == C_LAST_W) begin
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_w    <= w_next_w;
                        r_data <= i_words[int'(w_next_w)*WORD_W +: WORD_W];
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_data   = r_data;
    assign o_update = r_active && (r_cnt >= C_UPD_LO) && (r_cnt < C_UPD_HI);
    assign o_done   = r_done;

endmodule
`default_nettype wire

// File: rtl/dac_swv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dac_swv_sequencer
//  Description : Host-side segment scheduler for the SWV DAC engine. Holds a
//                NUM_SEG x 7 word table, and on go loads/starts/monitors each
//                segment in turn. Build option DAC_SEQ_LOOP_EN adds a loop_en
//                input that repeats the sequence until abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_swv_sequencer
    import dac_seq_pkg::*;
#(
    parameter int NUM_SEG    = 8,
    parameter int TRIG_WIDTH = 2,
    parameter int SETTLE_CYC = 4,
    parameter int ARM_TMO    = 16
)(
    input  logic                       ti_clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_SEG)-1:0] cfg_seg,
    input  logic [2:0]                 cfg_word,
    input  logic [15:0]                cfg_data,
    input  logic [$clog2(NUM_SEG):0]   seq_len,
    input  logic                       go,
    input  logic                       abort,
`ifdef DAC_SEQ_LOOP_EN
    input  logic                       loop_en,
`endif
    input  logic                       eng_enable,
    output logic [15:0]                eng_data,
    output logic                       eng_update,
    output logic                       eng_start,
    output logic                       eng_rst,
    output logic                       busy,
    output logic [$clog2(NUM_SEG)-1:0] cur_seg,
    output logic                       done,
    output logic                       err
);

    localparam int SEG_W = $clog2(NUM_SEG);
    localparam int LEN_W = SEG_W + 1;
    localparam int CNT_W = $clog2(ARM_TMO + TRIG_WIDTH + ABORT_CYC) + 1;
    localparam logic [CNT_W-1:0] C_TRIG_LAST  = CNT_W'(TRIG_WIDTH - 1);
    localparam logic [CNT_W-1:0] C_TMO_LAST   = CNT_W'(ARM_TMO - 1);
    localparam logic [CNT_W-1:0] C_ABORT_LAST = CNT_W'(ABORT_CYC - 1);
    localparam logic [LEN_W-1:0] C_MAX_LEN    = LEN_W'(NUM_SEG);

    seq_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [SEG_W-1:0]  r_cur_seg, w_seg_nxt;
    logic [LEN_W-1:0]  r_len, w_len_nxt;
    logic              r_err, w_err_nxt;
    logic              r_ld_start;
    logic              r_en_s1, r_en_s2;
    logic              w_go_ok, w_last, w_loop;
    logic              w_done, w_start, w_rst, w_ld_clear;
    logic              w_ld_update, w_ld_done;
    logic              w_tbl_we;
    logic [NUM_WORDS*WORD_W-1:0] w_words;

    logic [WORD_W-1:0] r_table [NUM_SEG][NUM_WORDS];

    // A go is taken only in IDLE, only without a concurrent abort, and only
    // with a segment count the table can supply.
    assign w_go_ok  = go && !abort && (seq_len != '0) && (seq_len <= C_MAX_LEN);
    assign w_last   = ({1'b0, r_cur_seg} == (r_len - 1'b1));
    assign w_tbl_we = cfg_we && (r_state == S_IDLE) && (cfg_word < 3'(NUM_WORDS));

    // Table writes are accepted only while idle; contents are not reset.
    always_ff @(posedge ti_clk) begin
        if (w_tbl_we) begin
            r_table[cfg_seg][cfg_word] <= cfg_data;
        end
    end

    generate
        for (genvar gw = 0; gw < NUM_WORDS; gw++) begin : g_words
            assign w_words[gw*WORD_W +: WORD_W] = r_table[r_cur_seg][gw];
        end
    endgenerate

`ifdef DAC_SEQ_LOOP_EN
    logic r_loop;
    // Loop mode is captured together with seq_len on an accepted go.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loop <= 1'b0;
        end else if ((r_state == S_IDLE) && w_go_ok) begin
            r_loop <= loop_en;
        end
    end
    assign w_loop = r_loop;
`else
    assign w_loop = 1'b0;
`endif

    // State, counters and the two-flop synchroniser for the engine enable,
    // which is produced outside this clock's posedge timing.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cur_seg  <= '0;
            r_len      <= '0;
            r_err      <= 1'b0;
            r_ld_start <= 1'b0;
            r_en_s1    <= 1'b0;
            r_en_s2    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_seg  <= w_seg_nxt;
            r_len      <= w_len_nxt;
            r_err      <= w_err_nxt;
            r_ld_start <= (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
            r_en_s1    <= eng_enable;
            r_en_s2    <= r_en_s1;
        end
    end

    // Next-state and strobe decode; abort overrides every busy state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_seg_nxt   = r_cur_seg;
        w_len_nxt   = r_len;
        w_err_nxt   = r_err;
        w_done      = 1'b0;
        w_start     = 1'b0;
        w_rst       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go && !abort) begin
                    if (w_go_ok) begin
                        w_state_nxt = S_LOAD;
                        w_seg_nxt   = '0;
                        w_len_nxt   = seq_len;
                        w_err_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (w_ld_done) begin
                    w_state_nxt = S_ARM;
                    w_cnt_nxt   = '0;
                end
            end
            S_ARM: begin
                w_start = 1'b1;
                if (r_cnt == C_TRIG_LAST) begin
                    w_state_nxt = S_WAIT_EN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_EN: begin
                if (r_en_s2) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TMO_LAST) begin
                    w_state_nxt = S_ABORT;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // RUN is entered with the synchronised enable high, so a low
                // level here marks the falling edge.
                if (!r_en_s2) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (w_last) begin
                    w_done = 1'b1;
                    if (w_loop) begin
                        w_seg_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_seg_nxt   = r_cur_seg + 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_ABORT: begin
                w_rst = 1'b1;
                if (r_cnt == C_ABORT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (abort && (r_state != S_IDLE) && (r_state != S_ABORT)) begin
            w_state_nxt = S_ABORT;
            w_cnt_nxt   = '0;
            w_done      = 1'b0;
        end
    end

    assign w_ld_clear = (w_state_nxt == S_ABORT);

    dac_seq_word_loader #(
        .TRIG_WIDTH (TRIG_WIDTH),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_loader (
        .ti_clk   (ti_clk),
        .rst_n    (rst_n),
        .i_start  (r_ld_start),
        .i_clear  (w_ld_clear),
        .i_words  (w_words),
        .o_data   (eng_data),
        .o_update (w_ld_update),
        .o_done   (w_ld_done)
    );

    assign eng_update = w_ld_update && (r_state == S_LOAD);
    assign eng_start  = w_start;
    assign eng_rst    = w_rst;
    assign busy       = (r_state != S_IDLE) && (r_state != S_ABORT);
    assign cur_seg    = r_cur_seg;
    assign done       = w_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dac_swv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_swv_sequencer
//  Description : Self-checking bench for dac_swv_sequencer with a simple
//                engine model that raises enable after eng_start and drops
//                it after run_len cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_swv_sequencer;

    localparam int NUM_SEG    = 8;
    localparam int TRIG_WIDTH = 2;
    localparam int SETTLE_CYC = 4;
    localparam int ARM_TMO    = 16;
    localparam int WORD_CYC   = 2*SETTLE_CYC + TRIG_WIDTH;

    logic        ti_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_seg = '0;
    logic [2:0]  cfg_word = '0;
    logic [15:0] cfg_data = '0;
    logic [3:0]  seq_len = '0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
`ifdef DAC_SEQ_LOOP_EN
    logic        loop_en = 1'b0;
`endif
    logic        eng_enable = 1'b0;
    logic [15:0] eng_data;
    logic        eng_update, eng_start, eng_rst, busy, done, err;
    logic [2:0]  cur_seg;

    dac_swv_sequencer #(
        .NUM_SEG(NUM_SEG), .TRIG_WIDTH(TRIG_WIDTH),
        .SETTLE_CYC(SETTLE_CYC), .ARM_TMO(ARM_TMO)
    ) dut (
        .ti_clk(ti_clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_seg(cfg_seg),
        .cfg_word(cfg_word), .cfg_data(cfg_data), .seq_len(seq_len),
        .go(go), .abort(abort),
`ifdef DAC_SEQ_LOOP_EN
        .loop_en(loop_en),
`endif
        .eng_enable(eng_enable), .eng_data(eng_data), .eng_update(eng_update),
        .eng_start(eng_start), .eng_rst(eng_rst), .busy(busy),
        .cur_seg(cur_seg), .done(done), .err(err)
    );

    always #5 ti_clk = ~ti_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ti_clk);
            #1;
        end
    endtask

    // Engine model: enable rises the cycle after a start strobe, falls after run_len.
    int   run_len  = 400;
    bit   no_en    = 1'b0;
    int   en_timer = 0;
    logic st_prev  = 1'b0;
    always @(posedge ti_clk) begin
        st_prev <= eng_start;
        if (eng_rst) begin
            eng_enable <= 1'b0;
            en_timer   <= 0;
        end else if (eng_start && !st_prev && !no_en) begin
            eng_enable <= 1'b1;
            en_timer   <= run_len;
        end else if (en_timer > 0) begin
            if (en_timer == 1) eng_enable <= 1'b0;
            en_timer <= en_timer - 1;
        end
    end

    // Observation log, sampled on the falling edge.
    int          cyc = 0;
    logic [15:0] upd_data[$];
    int          upd_cyc[$];
    logic [2:0]  upd_seg[$];
    int          start_cyc[$];
    logic [2:0]  start_seg[$];
    int          rst_rise[$];
    int          fall_cyc[$];
    int          done_cnt = 0;
    int          rst_hi   = 0;
    logic        p_upd = 1'b0, p_start = 1'b0, p_rst = 1'b0, p_en = 1'b0;
    always @(negedge ti_clk) begin
        cyc++;
        if (eng_update && !p_upd) begin
            upd_data.push_back(eng_data);
            upd_cyc.push_back(cyc);
            upd_seg.push_back(cur_seg);
        end
        if (eng_start && !p_start) begin
            start_cyc.push_back(cyc);
            start_seg.push_back(cur_seg);
        end
        if (eng_rst && !p_rst) rst_rise.push_back(cyc);
        if (p_en && !eng_enable) fall_cyc.push_back(cyc);
        if (done) done_cnt++;
        if (eng_rst) rst_hi++;
        p_upd = eng_update; p_start = eng_start; p_rst = eng_rst; p_en = eng_enable;
    end

    task automatic write_word(input int seg, input int word, input logic [15:0] data);
        cfg_we = 1'b1; cfg_seg = 3'(seg); cfg_word = 3'(word); cfg_data = data;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_go(input int len, input bit with_abort);
        go = 1'b1; abort = with_abort; seq_len = 4'(len);
        tick(1);
        go = 1'b0; abort = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    typedef struct {
        int len;
        bit with_abort;
        bit exp_busy;
        bit exp_err;
    } go_vec_t;

    logic [15:0] seg_words[7];
    logic [15:0] einit[3];
    go_vec_t     vt[7];

    initial begin
        int ub, sb, db, rb, fb, n;

        seg_words = '{16'h0800, 16'h0400, 16'h0010, 16'h0FF0, 16'h0000, 16'h0064, 16'h0003};
        einit     = '{16'h0400, 16'h0111, 16'h0222};
        vt[0] = '{len: 0,  with_abort: 0, exp_busy: 0, exp_err: 1};
        vt[1] = '{len: 9,  with_abort: 0, exp_busy: 0, exp_err: 1};
        vt[2] = '{len: 1,  with_abort: 0, exp_busy: 1, exp_err: 0};
        vt[3] = '{len: 15, with_abort: 0, exp_busy: 0, exp_err: 1};
        vt[4] = '{len: 1,  with_abort: 1, exp_busy: 0, exp_err: 1};
        vt[5] = '{len: 8,  with_abort: 0, exp_busy: 1, exp_err: 0};
        vt[6] = '{len: 0,  with_abort: 0, exp_busy: 0, exp_err: 1};

        // Reset state
        tick(3);
        check("rst busy", busy, 1'b0);
        check("rst err", err, 1'b0);
        check("rst done", done, 1'b0);
        check("rst eng_data", eng_data, 16'h0000);
        check("rst strobes", {eng_update, eng_start, eng_rst}, 3'b000);
        check("rst cur_seg", cur_seg, 3'd0);
        rst_n = 1'b1;
        tick(2);

        // Table fill: every segment gets the base words, segs 1/2 a distinct e_init
        for (int s = 0; s < NUM_SEG; s++)
            for (int w = 0; w < 7; w++)
                write_word(s, w, (w == 1 && s < 3) ? einit[s] : seg_words[w]);

        // Go/seq_len vectors, including go+abort collision
        for (int i = 0; i < 7; i++) begin
            sb = start_cyc.size();
            pulse_go(vt[i].len, vt[i].with_abort);
            check($sformatf("vec%0d busy", i), busy, vt[i].exp_busy);
            check($sformatf("vec%0d err", i), err, vt[i].exp_err);
            if (busy) begin
                tick(2);
                pulse_abort();
                tick(4);
            end
            check($sformatf("vec%0d no start", i), start_cyc.size(), sb);
        end

        // T1: single segment
        ub = upd_data.size(); sb = start_cyc.size(); db = done_cnt;
        run_len = 400;
        pulse_go(1, 0);
        check("T1 err cleared", err, 1'b0);
        wait_idle(1000, "T1 finish");
        check("T1 update count", upd_data.size(), ub + 7);
        if (upd_data.size() >= ub + 7) begin
            for (int k = 0; k < 7; k++)
                check($sformatf("T1 word%0d", k), upd_data[ub+k], seg_words[k]);
            for (int k = 1; k < 7; k++)
                check($sformatf("T1 spacing%0d", k), upd_cyc[ub+k] - upd_cyc[ub+k-1], WORD_CYC);
        end
        check("T1 starts", start_cyc.size(), sb + 1);
        check("T1 done", done_cnt, db + 1);

        // T2: three segments
        ub = upd_data.size(); sb = start_cyc.size(); db = done_cnt; fb = fall_cyc.size();
        run_len = 50;
        pulse_go(3, 0);
        wait_idle(1000, "T2 finish");
        check("T2 update count", upd_data.size(), ub + 21);
        check("T2 starts", start_cyc.size(), sb + 3);
        check("T2 done", done_cnt, db + 1);
        if (upd_data.size() >= ub + 21 && fall_cyc.size() >= fb + 2) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("T2 e_init seg%0d", k), upd_data[ub+1+7*k], einit[k]);
                check($sformatf("T2 cur_seg seg%0d", k), upd_seg[ub+7*k], 3'(k));
            end
            for (int k = 1; k < 3; k++)
                check($sformatf("T2 load after fall%0d", k), upd_cyc[ub+7*k] > fall_cyc[fb+k-1], 1'b1);
        end

        // T3a: abort while loading word 3
        ub = upd_data.size(); db = done_cnt; rb = rst_hi;
        run_len = 400;
        pulse_go(1, 0);
        n = 0;
        while (upd_data.size() < ub + 3 && n < 100) begin tick(1); n++; end
        check("T3a reach word2", upd_data.size(), ub + 3);
        tick(7);
        pulse_abort();
        check("T3a rst c1", eng_rst, 1'b1);
        check("T3a busy", busy, 1'b0);
        tick(1);
        check("T3a rst c2", eng_rst, 1'b1);
        tick(1);
        check("T3a rst end", eng_rst, 1'b0);
        tick(30);
        check("T3a no more updates", upd_data.size(), ub + 3);
        check("T3a no done", done_cnt, db);
        check("T3a rst cycles", rst_hi, rb + 2);

        // T3b: abort during RUN
        ub = upd_data.size(); db = done_cnt; rb = rst_hi;
        pulse_go(1, 0);
        n = 0;
        while (!eng_enable && n < 200) begin tick(1); n++; end
        check("T3b enable up", eng_enable, 1'b1);
        tick(20);
        pulse_abort();
        check("T3b busy", busy, 1'b0);
        tick(12);
        check("T3b rst cycles", rst_hi, rb + 2);
        check("T3b engine stopped", eng_enable, 1'b0);
        check("T3b no done", done_cnt, db);
        check("T3b updates", upd_data.size(), ub + 7);

        // T5: engine never enables -> timeout
        sb = start_cyc.size(); rb = rst_rise.size(); db = done_cnt;
        no_en = 1'b1;
        pulse_go(1, 0);
        wait_idle(300, "T5 finish");
        tick(4);
        check("T5 err", err, 1'b1);
        check("T5 no done", done_cnt, db);
        if (start_cyc.size() > sb && rst_rise.size() > rb)
            check("T5 timeout delay", rst_rise[rb] - start_cyc[sb], TRIG_WIDTH + ARM_TMO);
        else
            check("T5 start/rst seen", 1'b0, 1'b1);
        no_en = 1'b0;

        // T6: table write and go while running are ignored
        sb = start_cyc.size(); db = done_cnt;
        run_len = 100;
        pulse_go(1, 0);
        n = 0;
        while (!eng_enable && n < 200) begin tick(1); n++; end
        write_word(0, 0, 16'hDEAD);
        pulse_go(2, 0);
        wait_idle(500, "T6 finish");
        check("T6 one start", start_cyc.size(), sb + 1);
        check("T6 one done", done_cnt, db + 1);
        ub = upd_data.size();
        pulse_go(1, 0);
        n = 0;
        while (upd_data.size() < ub + 1 && n < 100) begin tick(1); n++; end
        if (upd_data.size() > ub)
            check("T6 table unchanged", upd_data[ub], 16'h0800);
        else
            check("T6 readback seen", 1'b0, 1'b1);

        // Reset mid-load
        tick(5);
        rst_n = 1'b0;
        tick(1);
        check("midrst busy", busy, 1'b0);
        check("midrst eng_data", eng_data, 16'h0000);
        check("midrst strobes", {eng_update, eng_start, eng_rst}, 3'b000);
        rst_n = 1'b1;
        tick(3);

`ifdef DAC_SEQ_LOOP_EN
        // Loop mode: segments 0,1,0,1 with one done per wrap
        sb = start_cyc.size(); db = done_cnt;
        run_len = 30;
        loop_en = 1'b1;
        pulse_go(2, 0);
        loop_en = 1'b0;
        n = 0;
        while (start_cyc.size() < sb + 4 && n < 1000) begin tick(1); n++; end
        check("loop starts", start_cyc.size(), sb + 4);
        if (start_cyc.size() >= sb + 4)
            for (int k = 0; k < 4; k++)
                check($sformatf("loop seg%0d", k), start_seg[sb+k], 3'(k % 2));
        check("loop done", done_cnt, db + 1);
        check("loop busy", busy, 1'b1);
        pulse_abort();
        tick(4);
        check("loop stopped", busy, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
